gcd_requester: RTL and testbench

- Initiator side of the gcd start/done protocol.
- Accepts operand pairs on a valid/ready input stream and issues each pair to one gcd instance with a single-cycle start pulse.
- Waits for done, captures the result and presents it on a valid/ready output stream.
- Sits between the operand source and the gcd core, guarding the core against divide-by-zero and hangs.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_requester_if.sv | 31 +++
 rtl/gcd_timeout_cnt.sv | 20 ++
 rtl/gcd_requester.sv | 100 ++++++++++
 tb/tb_gcd_requester.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd requester and its timeout counter.
package gcd_pkg;
  localparam int DATA_W         = 32;
  // Worst-case Euclid iteration count for 32-bit operands.
  localparam int GCD_WORST_ITER = 47;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    RECOVER
  } state_e;
endpackage

// File: rtl/gcd_requester_if.sv
// Operand stream, result stream and gcd core start/done bundle.
interface gcd_requester_if #(
  parameter int DATA_W = gcd_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_gcd;
  logic              out_err;
  logic [DATA_W-1:0] gcd_opa;
  logic [DATA_W-1:0] gcd_opb;
  logic              gcd_start;
  logic              gcd_reset;
  logic [DATA_W-1:0] gcd_result;
  logic              gcd_done;

  modport master (
    input  in_valid, in_a, in_b, out_ready, gcd_result, gcd_done,
    output in_ready, out_valid, out_gcd, out_err,
           gcd_opa, gcd_opb, gcd_start, gcd_reset
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, gcd_result, gcd_done,
    input  in_ready, out_valid, out_gcd, out_err,
           gcd_opa, gcd_opb, gcd_start, gcd_reset
  );
endinterface

// File: rtl/gcd_timeout_cnt.sv
// Clear/enable counter; tc flags the last allowed cycle before TERM is reached.
module gcd_timeout_cnt #(
  parameter int TERM = 64,
  parameter int W    = $clog2(TERM + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (en && (cnt != W'(TERM)))   cnt <= cnt + W'(1);
  end

  assign tc = (cnt == W'(TERM - 1));
endmodule

// File: rtl/gcd_requester.sv
// Issues operand pairs to a gcd core with start/done, bypasses b==0 and
// aborts with an error result (plus a core reset pulse) if done never comes.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int DATA_W  = gcd_pkg::DATA_W,
  parameter int TIMEOUT = 64,
  localparam int TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  gcd_requester_if.master bus
);
  if (TIMEOUT < GCD_WORST_ITER + 3) begin : g_bad_timeout
    $error("gcd_requester: TIMEOUT must cover the worst-case core latency");
  end
  if (DATA_W != gcd_pkg::DATA_W) begin : g_bad_width
    $error("gcd_requester: DATA_W must match the gcd core width");
  end

  state_e          state;
  logic [TO_W-1:0] cnt;
  logic            tc;
  logic            first_wait;

  gcd_timeout_cnt #(.TERM(TIMEOUT), .W(TO_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ISSUE),
    .en    (state == WAIT),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Core clears done on the start edge, but the level seen in the first
  // WAIT cycle may still be the previous op's.
  assign first_wait = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_gcd   <= '0;
      bus.out_err   <= 1'b0;
      bus.gcd_opa   <= '0;
      bus.gcd_opb   <= '0;
      bus.gcd_start <= 1'b0;
      bus.gcd_reset <= 1'b0;
    end else begin
      bus.gcd_start <= 1'b0;
      bus.gcd_reset <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            if (bus.in_b == '0) begin
              bus.out_gcd   <= bus.in_a;
              bus.out_err   <= 1'b0;
              bus.out_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.gcd_opa   <= bus.in_a;
              bus.gcd_opb   <= bus.in_b;
              bus.gcd_start <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.gcd_done && !first_wait) begin
            bus.out_gcd   <= bus.gcd_result;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= RESP;
          end else if (tc) begin
            bus.out_gcd   <= '0;
            bus.out_err   <= 1'b1;
            bus.gcd_reset <= 1'b1;
            state         <= RECOVER;
          end
        end
        RECOVER: begin
          bus.out_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural gcd core (real, hang, stuck-done).
module tb_gcd_requester;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_requester_if #(.DATA_W(32)) ifc ();

  gcd_requester #(.DATA_W(32), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Core model: mode 0 = Euclid, 1 = never done, 2 = done stuck high with 0x55.
  int          mode = 0;
  logic        c_done, c_busy;
  logic [31:0] c_res, c_x, c_y;
  assign ifc.gcd_result = c_res;
  assign ifc.gcd_done   = c_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c_done <= 1'b0; c_busy <= 1'b0; c_res <= '0; c_x <= '0; c_y <= '0;
    end else if (ifc.gcd_reset) begin
      c_done <= 1'b0; c_busy <= 1'b0;
    end else if (mode == 2) begin
      c_done <= 1'b1; c_res <= 32'h55;
    end else if (ifc.gcd_start) begin
      c_busy <= 1'b1; c_done <= 1'b0; c_x <= ifc.gcd_opa; c_y <= ifc.gcd_opb;
    end else if (c_busy && mode == 0) begin
      if (c_y == 0) begin
        c_res <= c_x; c_done <= 1'b1; c_busy <= 1'b0;
      end else begin
        c_x <= c_y; c_y <= c_x % c_y;
      end
    end
  end

  int n_start = 0, n_greset = 0;
  always @(negedge clk) begin
    if (ifc.gcd_start === 1'b1) n_start++;
    if (ifc.gcd_reset === 1'b1) n_greset++;
  end

  int total = 0, bad = 0;

  task automatic send(input logic [31:0] a, input logic [31:0] b, output bit acc);
    acc = 1'b0;
    ifc.in_a = a; ifc.in_b = b; ifc.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ifc.in_ready) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  // lat = 1 when out_valid is already up right after the accepting edge
  task automatic wait_out(input int limit, output int lat);
    lat = 1;
    while (!ifc.out_valid && lat < limit) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    ifc.in_a = '0; ifc.in_b = '0;
    #3;
    total++;
    if ({ifc.in_ready, ifc.out_valid, ifc.out_err, ifc.gcd_start, ifc.gcd_reset} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000",
        {ifc.in_ready, ifc.out_valid, ifc.out_err, ifc.gcd_start, ifc.gcd_reset});
    end
    total++;
    if ({ifc.out_gcd, ifc.gcd_opa, ifc.gcd_opb} !== 96'b0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", ifc.out_gcd, ifc.gcd_opa, ifc.gcd_opb);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle_ready got=%b want=1", ifc.in_ready);
    end
  endtask

  task automatic test_normal();
    bit acc; int lat; int s0;
    s0 = n_start;
    send(32'd48, 32'd18, acc);
    wait_out(60, lat);
    total++;
    if (!acc || ifc.out_valid !== 1'b1) begin
      bad++; $display("FAIL normal_valid acc=%0b valid=%b want 1/1", acc, ifc.out_valid);
    end
    total++;
    if (ifc.out_gcd !== 32'd6 || ifc.out_err !== 1'b0) begin
      bad++; $display("FAIL normal_result got=%0d err=%b want=6 err=0", ifc.out_gcd, ifc.out_err);
    end
    total++;
    if (lat < 4) begin
      bad++; $display("FAIL normal_latency got=%0d want>=4", lat);
    end
    total++;
    if (ifc.gcd_opa !== 32'd48 || ifc.gcd_opb !== 32'd18) begin
      bad++; $display("FAIL normal_ops got=%0d,%0d want=48,18", ifc.gcd_opa, ifc.gcd_opb);
    end
    @(posedge clk); #1;
    total++;
    if (ifc.out_valid !== 1'b0) begin
      bad++; $display("FAIL normal_one_cycle got=%b want=0", ifc.out_valid);
    end
    total++;
    if (n_start - s0 !== 1) begin
      bad++; $display("FAIL normal_start_pulses got=%0d want=1", n_start - s0);
    end
  endtask

  task automatic test_bypass();
    bit acc; int lat; int s0;
    s0 = n_start;
    send(32'd12, 32'd0, acc);
    wait_out(20, lat);
    total++;
    if (!acc || lat !== 1 || ifc.out_gcd !== 32'd12 || ifc.out_err !== 1'b0) begin
      bad++; $display("FAIL bypass_12 acc=%0b lat=%0d gcd=%0d err=%b want 1/1/12/0",
        acc, lat, ifc.out_gcd, ifc.out_err);
    end
    @(posedge clk); #1;
    send(32'd0, 32'd0, acc);
    wait_out(20, lat);
    total++;
    if (!acc || lat !== 1 || ifc.out_gcd !== 32'd0 || ifc.out_valid !== 1'b1) begin
      bad++; $display("FAIL bypass_00 acc=%0b lat=%0d gcd=%0d valid=%b want 1/1/0/1",
        acc, lat, ifc.out_gcd, ifc.out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (n_start - s0 !== 0) begin
      bad++; $display("FAIL bypass_no_start got=%0d want=0", n_start - s0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc; int lat; int s0;
    s0 = n_start;
    ifc.out_ready = 1'b0;
    send(32'd0, 32'd7, acc);
    wait_out(60, lat);
    ifc.in_a = 32'd17; ifc.in_b = 32'd5; ifc.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (ifc.out_valid !== 1'b1 || ifc.out_gcd !== 32'd7 || ifc.in_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_hold cyc=%0d valid=%b gcd=%0d in_ready=%b want 1/7/0",
          i, ifc.out_valid, ifc.out_gcd, ifc.in_ready);
      end
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_release valid=%b in_ready=%b want 0/1", ifc.out_valid, ifc.in_ready);
    end
    send(32'd17, 32'd5, acc);
    wait_out(60, lat);
    total++;
    if (!acc || ifc.out_valid !== 1'b1 || ifc.out_gcd !== 32'd1) begin
      bad++; $display("FAIL b2b_second acc=%0b valid=%b gcd=%0d want 1/1/1", acc, ifc.out_valid, ifc.out_gcd);
    end
    @(posedge clk); #1;
    total++;
    if (n_start - s0 !== 2) begin
      bad++; $display("FAIL b2b_starts got=%0d want=2", n_start - s0);
    end
  endtask

  task automatic test_timeout();
    bit acc; int lat; int r0;
    mode = 1;
    r0 = n_greset;
    send(32'd5, 32'd3, acc);
    wait_out(100, lat);
    // 1 issue + 64 wait + 1 recover cycles, counted from the accept edge
    total++;
    if (!acc || lat !== 67) begin
      bad++; $display("FAIL timeout_latency acc=%0b got=%0d want=67", acc, lat);
    end
    total++;
    if (ifc.out_err !== 1'b1 || ifc.out_gcd !== 32'd0) begin
      bad++; $display("FAIL timeout_result err=%b gcd=%0d want 1/0", ifc.out_err, ifc.out_gcd);
    end
    total++;
    if (n_greset - r0 !== 1) begin
      bad++; $display("FAIL timeout_core_reset got=%0d want=1", n_greset - r0);
    end
    @(posedge clk); #1;
    mode = 0;
    send(32'd9, 32'd6, acc);
    wait_out(60, lat);
    total++;
    if (!acc || ifc.out_valid !== 1'b1 || ifc.out_gcd !== 32'd3 || ifc.out_err !== 1'b0) begin
      bad++; $display("FAIL timeout_next acc=%0b valid=%b gcd=%0d err=%b want 1/1/3/0",
        acc, ifc.out_valid, ifc.out_gcd, ifc.out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stuck_done();
    bit acc; int lat;
    mode = 2;
    @(posedge clk); #1;
    send(32'd40, 32'd8, acc);
    wait_out(20, lat);
    total++;
    if (!acc || lat !== 4) begin
      bad++; $display("FAIL stuck_latency acc=%0b got=%0d want=4", acc, lat);
    end
    total++;
    if (ifc.out_gcd !== 32'h55 || ifc.out_err !== 1'b0) begin
      bad++; $display("FAIL stuck_result got=%h err=%b want=55 err=0", ifc.out_gcd, ifc.out_err);
    end
    @(posedge clk); #1;
    mode = 0;
  endtask

  task automatic test_reset_mid();
    bit acc; int lat;
    mode = 1;
    send(32'd4, 32'd2, acc);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (!acc || ifc.gcd_opa !== 32'd4 || ifc.in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_wait acc=%0b opa=%0d in_ready=%b want 1/4/0", acc, ifc.gcd_opa, ifc.in_ready);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ifc.in_ready, ifc.out_valid, ifc.out_err, ifc.gcd_start, ifc.gcd_reset} !== 5'b0 ||
        {ifc.out_gcd, ifc.gcd_opa, ifc.gcd_opb} !== 96'b0) begin
      bad++; $display("FAIL mid_async_reset ctrl=%b opa=%0d opb=%0d gcd=%0d want all 0",
        {ifc.in_ready, ifc.out_valid, ifc.out_err, ifc.gcd_start, ifc.gcd_reset},
        ifc.gcd_opa, ifc.gcd_opb, ifc.out_gcd);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mode = 0;
    @(posedge clk); #1;
    total++;
    if (ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready_after got=%b want=1", ifc.in_ready);
    end
    send(32'd21, 32'd14, acc);
    wait_out(60, lat);
    total++;
    if (!acc || ifc.out_valid !== 1'b1 || ifc.out_gcd !== 32'd7 || ifc.out_err !== 1'b0) begin
      bad++; $display("FAIL mid_next acc=%0b valid=%b gcd=%0d err=%b want 1/1/7/0",
        acc, ifc.out_valid, ifc.out_gcd, ifc.out_err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bypass();
    test_back_to_back();
    test_timeout();
    test_stuck_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
